// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fft_pkg
//  Purpose  : Shared defaults, complex-sample type and index bit reversal
//             for the FFT output path.
//  Revision : 1.0  initial release
// ============================================================================
package fft_pkg;

   localparam int DATA_W   = 16;
   localparam int N_POINTS = 16;
   localparam int LOG2N    = 4;

   // One complex sample; "real" is a keyword, hence re/im
   typedef struct packed {
      logic signed [DATA_W-1:0] re;
      logic signed [DATA_W-1:0] im;
   } cplx_t;

   // Reverse the lowest 'width' bits of 'value'; upper result bits are zero
   function automatic logic [31:0] bitrev(input logic [31:0] value, input int width);
      logic [31:0] result;
      int          src;
      result = '0;
      for (int b = 0; b < 32; b++) begin
         src = width - 1 - b;
         if (src >= 0) result[b] = value[src[4:0]];
      end
      return result;
   endfunction

endpackage
`default_nettype wire

// File: rtl/fft_reorder_bank.sv
`default_nettype none
// ============================================================================
//  Module   : fft_reorder_bank
//  Purpose  : One frame bank: registered write port, combinational read.
//             Contents are deliberately not reset.
//  Revision : 1.0  initial release
// ============================================================================
module fft_reorder_bank #(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4,
   parameter int WORD_W = 32
) (
   input  logic              clk,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [WORD_W-1:0] i_wdata,
   input  logic [ADDR_W-1:0] i_raddr,
   output logic [WORD_W-1:0] o_rdata
);
   import fft_pkg::*;

   logic [WORD_W-1:0] r_mem [DEPTH];

   // Store one sample per accepted write
   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end

   assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/fft_out_reorder.sv
`default_nettype none
// ============================================================================
//  Module   : fft_out_reorder
//  Purpose  : Converts bit-reversed FFT frames into natural index order using
//             a ping-pong pair of frame banks; push/stall on both sides.
//  Options  : FFT_REORDER_LAST_EN adds out_last, high on natural index N-1.
//  Revision : 1.0  initial release
// ============================================================================
module fft_out_reorder #(
   parameter int N_POINTS = 16,
   parameter int LOG2N    = 4,
   parameter int DATA_W   = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_push,
   input  logic [DATA_W-1:0] in_real,
   input  logic [DATA_W-1:0] in_imag,
   output logic              in_stall,
   output logic              out_push,
   output logic [DATA_W-1:0] out_real,
   output logic [DATA_W-1:0] out_imag,
`ifdef FFT_REORDER_LAST_EN
   output logic              out_last,
`endif
   input  logic              out_stall
);
   import fft_pkg::*;

   localparam logic [LOG2N-1:0] c_LAST_IDX = LOG2N'(N_POINTS - 1);

   logic [1:0]          r_full;
   logic                r_wr_bank;
   logic                r_rd_bank;
   logic [LOG2N-1:0]    r_wr_cnt;
   logic [LOG2N-1:0]    r_rd_cnt;
   logic                r_out_push;
   logic [DATA_W-1:0]   r_out_real;
   logic [DATA_W-1:0]   r_out_imag;
`ifdef FFT_REORDER_LAST_EN
   logic                r_out_last;
`endif

   logic                w_accept;
   logic                w_load;
   logic                w_wr_last;
   logic                w_rd_last;
   logic [LOG2N-1:0]    w_wr_addr;
   logic [2*DATA_W-1:0] w_bank_rdata [2];
   logic [2*DATA_W-1:0] w_rd_word;
   logic [1:0]          w_full_nxt;

   assign w_accept  = in_push & ~r_full[r_wr_bank];
   assign w_load    = r_full[r_rd_bank] & (~r_out_push | ~out_stall);
   assign w_wr_last = (r_wr_cnt == c_LAST_IDX);
   assign w_rd_last = (r_rd_cnt == c_LAST_IDX);
   assign w_wr_addr = LOG2N'(bitrev(32'(r_wr_cnt), LOG2N));
   assign w_rd_word = w_bank_rdata[r_rd_bank];

   // Two identical banks; the writer and reader each select one by bank index
   for (genvar gi = 0; gi < 2; gi++) begin : g_bank
      fft_reorder_bank #(
         .DEPTH  (N_POINTS),
         .ADDR_W (LOG2N),
         .WORD_W (2*DATA_W)
      ) u_bank (
         .clk     (clk),
         .i_we    (w_accept && (r_wr_bank == 1'(gi))),
         .i_waddr (w_wr_addr),
         .i_wdata ({in_real, in_imag}),
         .i_raddr (r_rd_cnt),
         .o_rdata (w_bank_rdata[gi])
      );
   end

   // Per-bank full flag: set by the writer finishing it, cleared by the reader
   // finishing it; the two can never target the same bank on one edge
   always_comb begin
      w_full_nxt = r_full;
      for (int b = 0; b < 2; b++) begin
         if (w_accept && w_wr_last && (r_wr_bank == 1'(b)))
            w_full_nxt[b] = 1'b1;
         else if (w_load && w_rd_last && (r_rd_bank == 1'(b)))
            w_full_nxt[b] = 1'b0;
      end
   end

   // Write/read pointers, bank flags and the registered output stage
   always_ff @(posedge clk) begin
      if (reset) begin
         r_full     <= '0;
         r_wr_bank  <= 1'b0;
         r_rd_bank  <= 1'b0;
         r_wr_cnt   <= '0;
         r_rd_cnt   <= '0;
         r_out_push <= 1'b0;
         r_out_real <= '0;
         r_out_imag <= '0;
`ifdef FFT_REORDER_LAST_EN
         r_out_last <= 1'b0;
`endif
      end else begin
         r_full <= w_full_nxt;

         if (w_accept) begin
            if (w_wr_last) begin
               r_wr_cnt  <= '0;
               r_wr_bank <= ~r_wr_bank;
            end else begin
               r_wr_cnt  <= r_wr_cnt + LOG2N'(1);
            end
         end

         if (w_load) begin
            r_out_push <= 1'b1;
            r_out_real <= w_rd_word[2*DATA_W-1:DATA_W];
            r_out_imag <= w_rd_word[DATA_W-1:0];
`ifdef FFT_REORDER_LAST_EN
            r_out_last <= w_rd_last;
`endif
            if (w_rd_last) begin
               r_rd_cnt  <= '0;
               r_rd_bank <= ~r_rd_bank;
            end else begin
               r_rd_cnt  <= r_rd_cnt + LOG2N'(1);
            end
         end else if (r_out_push && !out_stall) begin
            r_out_push <= 1'b0;
         end
      end
   end

   assign in_stall = r_full[r_wr_bank];
   assign out_push = r_out_push;
   assign out_real = r_out_real;
   assign out_imag = r_out_imag;
`ifdef FFT_REORDER_LAST_EN
   assign out_last = r_out_last;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fft_out_reorder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fft_out_reorder
//  Purpose  : Self-checking bench for fft_out_reorder: vector table for one
//             frame plus a queue scoreboard for streaming, stall and reset.
//  Options  : FFT_REORDER_LAST_EN also checks out_last.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fft_out_reorder;

   logic               clk = 1'b0;
   logic               reset;
   logic               in_push;
   logic signed [15:0] in_real;
   logic signed [15:0] in_imag;
   logic               in_stall;
   logic               out_push;
   logic signed [15:0] out_real;
   logic signed [15:0] out_imag;
   logic               out_stall;
`ifdef FFT_REORDER_LAST_EN
   logic               out_last;
`endif

   always #5 clk = ~clk;

   fft_out_reorder #(.N_POINTS(16), .LOG2N(4), .DATA_W(16)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_push   (in_push),
      .in_real   (in_real),
      .in_imag   (in_imag),
      .in_stall  (in_stall),
      .out_push  (out_push),
      .out_real  (out_real),
      .out_imag  (out_imag),
`ifdef FFT_REORDER_LAST_EN
      .out_last  (out_last),
`endif
      .out_stall (out_stall)
   );

   typedef struct {
      logic signed [15:0] re;
      logic signed [15:0] im;
      logic               last;
   } exp_t;

   typedef struct {
      logic signed [15:0] in_re;
      logic signed [15:0] in_im;
      logic signed [15:0] exp_re;
      logic signed [15:0] exp_im;
   } vec_t;

   exp_t               sb_q[$];
   logic signed [15:0] fr_re [16];
   logic signed [15:0] fr_im [16];
   int                 fr_cnt = 0;
   int                 total = 0;
   int                 bad = 0;
   int                 n_out = 0;
   int                 run = 0;
   int                 max_run = 0;
   int                 stall_cycles = 0;
   logic               hold_prev = 1'b0;
   logic signed [15:0] prev_re, prev_im;
   logic               prev_last;
   bit                 drv_done;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int brev4(input int x);
      logic [3:0] v;
      v = x[3:0];
      return int'({v[0], v[1], v[2], v[3]});
   endfunction

   // Present one sample, wait (bounded) until it is accepted; returns #1 after that edge
   task automatic drive(input logic signed [15:0] re, input logic signed [15:0] im);
      int waited;
      in_push = 1'b1;
      in_real = re;
      in_imag = im;
      waited  = 0;
      while (in_stall) begin
         stall_cycles++;
         @(posedge clk); #1;
         waited++;
         if (waited > 1000) begin
            chk("drive_timeout", 1, 0);
            break;
         end
      end
      @(posedge clk); #1;
   endtask

   // Wait (bounded) until every expected output has been delivered
   task automatic wait_drain();
      int waited;
      waited = 0;
      while (sb_q.size() != 0 || out_push) begin
         @(posedge clk); #1;
         waited++;
         if (waited > 2000) begin
            chk("drain_timeout", 1, 0);
            break;
         end
      end
   endtask

   // Reference model and output monitor: observes what will transfer on the next edge
   always @(negedge clk) begin
      exp_t e;
      if (reset) begin
         fr_cnt    = 0;
         sb_q.delete();
         hold_prev = 1'b0;
         run       = 0;
      end else begin
         if (hold_prev) begin
            chk("hold_push", int'(out_push), 1);
            chk("hold_real", int'(out_real), int'(prev_re));
            chk("hold_imag", int'(out_imag), int'(prev_im));
`ifdef FFT_REORDER_LAST_EN
            chk("hold_last", int'(out_last), int'(prev_last));
`endif
         end
         if (out_push && !out_stall) begin
            if (sb_q.size() == 0) begin
               chk("extra_output", 1, 0);
            end else begin
               e = sb_q.pop_front();
               chk("sb_real", int'(out_real), int'(e.re));
               chk("sb_imag", int'(out_imag), int'(e.im));
`ifdef FFT_REORDER_LAST_EN
               chk("sb_last", int'(out_last), int'(e.last));
`endif
            end
            n_out++;
         end
         if (out_push) run++; else run = 0;
         if (run > max_run) max_run = run;
         hold_prev = out_push && out_stall;
         prev_re   = out_real;
         prev_im   = out_imag;
`ifdef FFT_REORDER_LAST_EN
         prev_last = out_last;
`else
         prev_last = 1'b0;
`endif
         if (in_push && !in_stall) begin
            fr_re[fr_cnt] = in_real;
            fr_im[fr_cnt] = in_imag;
            fr_cnt++;
            if (fr_cnt == 16) begin
               for (int j = 0; j < 16; j++) begin
                  e.re   = fr_re[brev4(j)];
                  e.im   = fr_im[brev4(j)];
                  e.last = (j == 15);
                  sb_q.push_back(e);
               end
               fr_cnt = 0;
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl [16];
      int   ord [16];
      int   n0;
      ord = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
      for (int i = 0; i < 16; i++) begin
         tbl[i].in_re  = 16'(i);
         tbl[i].in_im  = 16'(-i);
         tbl[i].exp_re = 16'(ord[i]);
         tbl[i].exp_im = 16'(-ord[i]);
      end

      reset     = 1'b1;
      in_push   = 1'b0;
      in_real   = '0;
      in_imag   = '0;
      out_stall = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_push", int'(out_push), 0);
      chk("rst_out_real", int'(out_real), 0);
      chk("rst_out_imag", int'(out_imag), 0);
      chk("rst_in_stall", int'(in_stall), 0);
      reset = 1'b0;
      @(posedge clk); #1;

      // Single frame from the vector table, checked directly and via scoreboard
      for (int i = 0; i < 16; i++) drive(tbl[i].in_re, tbl[i].in_im);
      in_push = 1'b0;
      chk("sf_lat_edge_k", int'(out_push), 0);
      @(posedge clk); #1;
      chk("sf_lat_edge_k1", int'(out_push), 1);
      for (int i = 0; i < 16; i++) begin
         chk("sf_tbl_push", int'(out_push), 1);
         chk("sf_tbl_real", int'(out_real), int'(tbl[i].exp_re));
         chk("sf_tbl_imag", int'(out_imag), int'(tbl[i].exp_im));
         @(posedge clk); #1;
      end
      chk("sf_idle", int'(out_push), 0);
      chk("sf_sb_empty", sb_q.size(), 0);

      // Back-to-back frames at full rate
      max_run      = 0;
      stall_cycles = 0;
      n0           = n_out;
      for (int f = 0; f < 3; f++)
         for (int i = 0; i < 16; i++)
            drive(16'(f*16 + i), 16'(-(f*16 + i)));
      in_push = 1'b0;
      wait_drain();
      chk("btb_no_in_stall", stall_cycles, 0);
      chk("btb_contiguous", max_run, 48);
      chk("btb_count", n_out - n0, 48);

      // Full backpressure: both banks fill, head sample held
      out_stall = 1'b1;
      for (int i = 0; i < 32; i++) drive(16'(i), 16'(i + 500));
      in_push = 1'b0;
      chk("bp_in_stall", int'(in_stall), 1);
      chk("bp_out_push", int'(out_push), 1);
      chk("bp_out_real0", int'(out_real), 0);
      repeat (5) @(posedge clk);
      #1;
      chk("bp_in_stall_held", int'(in_stall), 1);
      chk("bp_out_real_held", int'(out_real), 0);
      n0        = n_out;
      out_stall = 1'b0;
      wait_drain();
      chk("bp_drain_count", n_out - n0, 32);
      chk("bp_in_stall_free", int'(in_stall), 0);

      // Random output stall across 4 frames
      n0       = n_out;
      drv_done = 1'b0;
      fork
         begin
            for (int f = 0; f < 4; f++)
               for (int i = 0; i < 16; i++)
                  drive(16'(1000 + f*16 + i), 16'(-7 * (f*16 + i)));
            in_push  = 1'b0;
            drv_done = 1'b1;
         end
         begin
            while (!drv_done) begin
               out_stall = 1'($urandom_range(0, 1));
               @(posedge clk); #1;
            end
         end
      join
      repeat (20) begin
         out_stall = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
      end
      out_stall = 1'b0;
      wait_drain();
      chk("rs_count", n_out - n0, 64);

      // Reset after 7 accepts; input present during reset must be ignored
      for (int i = 0; i < 7; i++) drive(16'(50 + i), 16'(50 + i));
      in_real = 16'(999);
      in_imag = 16'(999);
      reset   = 1'b1;
      @(posedge clk); #1;
      chk("mr_push_during", int'(out_push), 0);
      reset   = 1'b0;
      in_push = 1'b0;
      @(posedge clk); #1;
      chk("mr_push_after", int'(out_push), 0);
      chk("mr_in_stall", int'(in_stall), 0);
      n0 = n_out;
      for (int i = 0; i < 16; i++) drive(16'(100 + i), 16'(-(100 + i)));
      in_push = 1'b0;
      wait_drain();
      repeat (5) @(posedge clk);
      #1;
      chk("mr_count", n_out - n0, 16);
      chk("mr_idle", int'(out_push), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
